uart_tx_frame_mux: RTL and testbench

Parametrised UART transmit frame generator and output selector for the UART_TX path. Latches a parallel word on a valid/busy handshake and drives the serial line through start, data (LSB first), optional parity and stop bits. Frame sequencing and line-source selection happen in one block, with a registered, glitch-free line output. The block runs at one bit per CLK, so CLK is the baud-rate tick domain.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_frame_mux_if.sv | 23 ++
 rtl/uart_tx_line_mux.sv | 30 +++
 rtl/uart_tx_frame_mux.sv | 123 ++++++++++++
 tb/tb_uart_tx_frame_mux.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_tx_pkg;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    typedef enum logic [2:0] {SEL_IDLE, SEL_START, SEL_DATA, SEL_PARITY, SEL_STOP} sel_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_frame_mux_if.sv
// Request/line bundle between a word producer and uart_tx_frame_mux.
// SEND_BREAK is present only when UART_TX_BREAK_EN is defined.
interface uart_tx_frame_mux_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  BUSY;
`ifdef UART_TX_BREAK_EN
    logic                  SEND_BREAK;

    modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, SEND_BREAK,
                    input  TX_OUT, BUSY);
    modport slave  (input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, SEND_BREAK,
                    output TX_OUT, BUSY);
`else
    modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
                    input  TX_OUT, BUSY);
    modport slave  (input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
                    output TX_OUT, BUSY);
`endif
endinterface

// File: rtl/uart_tx_line_mux.sv
// Line-source selector feeding the registered, glitch-free TX line.
module uart_tx_line_mux
    import uart_tx_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  sel_t i_sel,
    input  logic i_data_bit,
    input  logic i_par_bit,
    output logic o_tx
);

    logic w_line;

    always_comb begin
        w_line = STOP_BIT;
        case (i_sel)
            SEL_START:  w_line = START_BIT;
            SEL_DATA:   w_line = i_data_bit;
            SEL_PARITY: w_line = i_par_bit;
            default:    w_line = STOP_BIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) o_tx <= STOP_BIT;
        else      o_tx <= w_line;
    end

endmodule

// File: rtl/uart_tx_frame_mux.sv
// UART frame sequencer: start, LSB-first data, optional parity, stop bits.
// Optional break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame_mux
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input logic               CLK,
    input logic               RST,
    uart_tx_frame_mux_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en, r_par_typ, r_busy;
    logic                  w_accept, w_data_bit, w_par_bit;
    sel_t                  w_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (bus.SEND_BREAK) w_state_nxt = BREAK;
                else
`endif
                if (bus.DATA_VALID) begin
                    w_state_nxt = START;
                    w_accept    = 1'b1;
                end
            end
            START: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = '0;
            end
            DATA: begin
                if (r_cnt == LAST_BIT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_par_en ? PARITY : STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PARITY: w_state_nxt = STOP;
            STOP: begin
                if (r_cnt == LAST_STOP) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (!bus.SEND_BREAK) begin
                    w_state_nxt = STOP;
                    w_cnt_nxt   = '0;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // The line register samples the source of the state being entered, so
    // TX_OUT and BUSY change together on the same edge as the FSM.
    always_comb begin
        w_sel = SEL_IDLE;
        case (w_state_nxt)
            START:   w_sel = SEL_START;
            DATA:    w_sel = SEL_DATA;
            PARITY:  w_sel = SEL_PARITY;
            STOP:    w_sel = SEL_STOP;
`ifdef UART_TX_BREAK_EN
            BREAK:   w_sel = SEL_START;  // break holds the line at space level
`endif
            default: w_sel = SEL_IDLE;
        endcase
    end

    assign w_data_bit = r_data[w_cnt_nxt];
    assign w_par_bit  = (^r_data) ^ (r_par_typ == PAR_ODD);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= PAR_EVEN;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_data    <= bus.P_DATA;
                r_par_en  <= bus.PAR_EN;
                r_par_typ <= bus.PAR_TYP;
            end
        end
    end

    assign bus.BUSY = r_busy;

    uart_tx_line_mux u_line_mux (
        .CLK       (CLK),
        .RST       (RST),
        .i_sel     (w_sel),
        .i_data_bit(w_data_bit),
        .i_par_bit (w_par_bit),
        .o_tx      (bus.TX_OUT)
    );

endmodule

// File: tb/tb_uart_tx_frame_mux.sv
// Scoreboard bench: instance A (1 stop bit) checks every line bit and frame
// length; instance B (2 stop bits) checks back-to-back period under held valid.
module tb_uart_tx_frame_mux;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_frame_mux_if #(.DATA_WIDTH(8)) bus_a();
    uart_tx_frame_mux_if #(.DATA_WIDTH(8)) bus_b();

    uart_tx_frame_mux #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .CLK(clk), .RST(rst_n), .bus(bus_a)
    );
    uart_tx_frame_mux #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
        .CLK(clk), .RST(rst_n), .bus(bus_b)
    );

    int n_chk = 0;
    int n_err = 0;

    bit q_a[$];
    int l_a[$];
    int run_a    = 0;
    bit mon_a_on = 1'b0;

    bit mon_b_on   = 1'b0;
    int cyc_b      = 0;
    int last_b     = -1;
    int nstart_b   = 0;
    logic prev_tx_b   = 1'b1;
    logic prev_busy_b = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input int sb);
        q_a.push_back(1'b0);
        for (int i = 0; i < 8; i++) q_a.push_back(d[i]);
        if (pe) q_a.push_back((^d) ^ pt);
        for (int i = 0; i < sb; i++) q_a.push_back(1'b1);
        l_a.push_back(1 + 8 + int'(pe) + sb);
    endtask

    // Scoreboard: every busy cycle pops one expected line bit; the falling
    // edge of BUSY pops the expected frame length.
    always @(negedge clk) begin
        if (mon_a_on) begin
            if (bus_a.BUSY === 1'b1) begin
                if (q_a.size() == 0) chk("a_unexp_busy", 32'(q_a.size()), 32'd1);
                else chk("a_tx_bit", 32'(bus_a.TX_OUT), 32'(q_a.pop_front()));
                run_a++;
            end else if (run_a > 0) begin
                chk("a_idle_tx", 32'(bus_a.TX_OUT), 32'd1);
                if (l_a.size() == 0) chk("a_unexp_len", 32'(l_a.size()), 32'd1);
                else chk("a_frame_len", 32'(run_a), 32'(l_a.pop_front()));
                run_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_b_on) begin
            cyc_b++;
            if (prev_tx_b === 1'b1 && bus_b.TX_OUT === 1'b0) begin
                if (last_b >= 0) begin
                    chk("b_period", 32'(cyc_b - last_b), 32'd12);
                    chk("b_gap_idle", 32'(prev_busy_b), 32'd0);
                end
                last_b = cyc_b;
                nstart_b++;
            end
            prev_tx_b   = bus_b.TX_OUT;
            prev_busy_b = bus_b.BUSY;
        end
    end

    task automatic wait_idle_a(input int budget);
        int k = 0;
        while (bus_a.BUSY !== 1'b0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (bus_a.BUSY !== 1'b0) chk("a_timeout", 32'(bus_a.BUSY), 32'd0);
    endtask

    task automatic send_a(input logic [7:0] d, input logic pe, input logic pt);
        wait_idle_a(40);
        bus_a.P_DATA     = d;
        bus_a.PAR_EN     = pe;
        bus_a.PAR_TYP    = pt;
        bus_a.DATA_VALID = 1'b1;
        push_frame(d, pe, pt, 1);
        @(posedge clk); #1;
        bus_a.DATA_VALID = 1'b0;
        chk("a_accept_busy", 32'(bus_a.BUSY), 32'd1);
        chk("a_start_tx", 32'(bus_a.TX_OUT), 32'd0);
        // inputs scrambled mid-frame must not disturb the latched frame
        bus_a.P_DATA  = ~d;
        bus_a.PAR_EN  = ~pe;
        bus_a.PAR_TYP = ~pt;
        wait_idle_a(40);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus_a.P_DATA = 8'h00; bus_a.PAR_EN = 1'b0; bus_a.PAR_TYP = 1'b0;
        bus_a.DATA_VALID = 1'b1;
        bus_b.P_DATA = 8'h00; bus_b.PAR_EN = 1'b0; bus_b.PAR_TYP = 1'b0;
        bus_b.DATA_VALID = 1'b1;
`ifdef UART_TX_BREAK_EN
        bus_a.SEND_BREAK = 1'b0;
        bus_b.SEND_BREAK = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_tx", 32'(bus_a.TX_OUT), 32'd1);
            chk("rst_busy", 32'(bus_a.BUSY), 32'd0);
        end
        bus_a.DATA_VALID = 1'b0;
        bus_b.DATA_VALID = 1'b0;
        rst_n    = 1'b1;
        mon_a_on = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(bus_a.BUSY), 32'd0);

        send_a(8'hA5, 1'b0, 1'b0);
        send_a(8'h07, 1'b1, 1'b0);
        send_a(8'h07, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            send_a(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // held valid on the two-stop-bit instance
        bus_b.P_DATA     = 8'h00;
        bus_b.DATA_VALID = 1'b1;
        mon_b_on         = 1'b1;
        for (int k = 0; k < 80 && nstart_b < 4; k++) begin
            @(posedge clk); #1;
        end
        chk("b_starts", 32'(nstart_b), 32'd4);
        bus_b.DATA_VALID = 1'b0;
        mon_b_on         = 1'b0;

        // reset while data bit 3 is on the line
        wait_idle_a(40);
        bus_a.P_DATA = 8'h00; bus_a.PAR_EN = 1'b0; bus_a.PAR_TYP = 1'b0;
        bus_a.DATA_VALID = 1'b1;
        push_frame(8'h00, 1'b0, 1'b0, 1);
        @(posedge clk); #1;
        bus_a.DATA_VALID = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_tx", 32'(bus_a.TX_OUT), 32'd1);
        chk("rst_mid_busy", 32'(bus_a.BUSY), 32'd0);
        q_a.delete();
        l_a.delete();
        run_a = 0;
        rst_n = 1'b1;
        send_a(8'h3C, 1'b1, 1'b1);

`ifdef UART_TX_BREAK_EN
        wait_idle_a(40);
        bus_a.P_DATA     = 8'hFF;
        bus_a.SEND_BREAK = 1'b1;
        bus_a.DATA_VALID = 1'b1;
        for (int i = 0; i < 20; i++) q_a.push_back(1'b0);
        q_a.push_back(1'b1);
        l_a.push_back(21);
        repeat (20) @(posedge clk);
        #1;
        bus_a.SEND_BREAK = 1'b0;
        bus_a.DATA_VALID = 1'b0;
        wait_idle_a(40);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("a_q_drained", 32'(q_a.size()), 32'd0);
        chk("a_len_drained", 32'(l_a.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
